// File: rtl/imsic_csr_req.sv
`default_nettype none
// ============================================================================
// Module   : imsic_csr_req
// Purpose  : Hart-side initiator for the IMSIC interrupt-file CSR channel.
//            Issues one indirect-CSR access and returns the response.
// Revision : 1.0 - initial release
// ============================================================================
module imsic_csr_req #(
    parameter int NR_INTP_FILES   = 7,
    parameter int XLEN            = 64,
    parameter int INTP_FILE_WIDTH = 3,
    parameter int TIMEOUT_CYC     = 16
) (
    input  logic                       clk,
    input  logic                       rst,

    input  logic                       req_vld,
    output logic                       req_rdy,
    input  logic [11:0]                req_iselect,
    input  logic [1:0]                 req_priv,
    input  logic                       req_v,
    input  logic [5:0]                 req_vgein,
    input  logic                       req_wen,
    input  logic [1:0]                 req_op,
    input  logic [XLEN-1:0]            req_wdata,

    output logic                       rsp_vld,
    input  logic                       rsp_rdy,
    output logic [XLEN-1:0]            rsp_rdata,
    output logic                       rsp_illegal,
    output logic                       rsp_timeout,

    output logic [11:0]                csr_addr,
    output logic                       csr_rd,
    output logic [INTP_FILE_WIDTH-1:0] intp_file_sel,
    output logic                       priv_is_illegal,
    output logic                       i_csr_v,
    output logic                       i_csr_wdata_vld,
    output logic [XLEN-1:0]            i_csr_wdata,
    output logic [1:0]                 i_csr_wdata_op,
    input  logic                       o_csr_rdata_vld,
    input  logic [XLEN-1:0]            o_csr_rdata,
    input  logic                       o_csr_illegal
);

    localparam int       c_max_vgein = NR_INTP_FILES - 2;
    localparam logic [7:0] c_cnt_last = 8'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic w_accept;
    logic w_hit;
    logic w_expire;

    logic [7:0]                 r_cnt;
    logic [11:0]                r_csr_addr;
    logic                       r_csr_rd;
    logic [INTP_FILE_WIDTH-1:0] r_sel;
    logic                       r_priv_ill;
    logic                       r_v;
    logic                       r_wdata_vld;
    logic [XLEN-1:0]            r_wdata;
    logic [1:0]                 r_op;
    logic [XLEN-1:0]            r_rsp_rdata;
    logic                       r_rsp_illegal;
    logic                       r_rsp_timeout;

    // Interrupt-file decode: M=0, S=1, VS files follow at 1+vgein.
    logic                       w_priv_bad;
    logic                       w_vgein_bad;
    logic                       w_priv_ill;
    logic [6:0]                 w_vs_idx;
    logic [INTP_FILE_WIDTH-1:0] w_sel;

    always_comb begin
        w_priv_bad  = !((req_priv == 2'd3) || (req_priv == 2'd1));
        w_vgein_bad = req_v && ((req_vgein == 6'd0) || (int'(req_vgein) > c_max_vgein));
        w_priv_ill  = w_priv_bad || w_vgein_bad;
        w_vs_idx    = {1'b0, req_vgein} + 7'd1;
        w_sel       = '0;
        if (w_priv_ill) begin
            w_sel = '0;
        end else if (req_v) begin
            w_sel = INTP_FILE_WIDTH'(w_vs_idx);
        end else if (req_priv == 2'd1) begin
            w_sel = INTP_FILE_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_hit       = 1'b0;
        w_expire    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (req_vld) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                w_state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                // A strobe on the terminal count wins over the timeout.
                if (o_csr_rdata_vld) begin
                    w_hit       = 1'b1;
                    w_state_nxt = ST_RESP;
                end else if (r_cnt == c_cnt_last) begin
                    w_expire    = 1'b1;
                    w_state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_rdy) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (r_state == ST_ISSUE) begin
            r_cnt <= '0;
        end else if ((r_state == ST_WAIT) && !w_hit && !w_expire) begin
            r_cnt <= r_cnt + 8'd1;
        end
    end

    // Channel outputs are loaded on acceptance so the strobe lines up with ISSUE.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_csr_addr  <= '0;
            r_csr_rd    <= 1'b0;
            r_sel       <= '0;
            r_priv_ill  <= 1'b0;
            r_v         <= 1'b0;
            r_wdata_vld <= 1'b0;
            r_wdata     <= '0;
            r_op        <= '0;
        end else if (w_accept) begin
            r_csr_addr  <= req_iselect;
            r_csr_rd    <= 1'b1;
            r_sel       <= w_sel;
            r_priv_ill  <= w_priv_ill;
            r_v         <= req_v;
            r_wdata_vld <= req_wen;
            r_wdata     <= req_wdata;
            r_op        <= req_op;
        end else begin
            r_csr_rd    <= 1'b0;
            r_wdata_vld <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rsp_rdata   <= '0;
            r_rsp_illegal <= 1'b0;
            r_rsp_timeout <= 1'b0;
        end else if (w_hit) begin
            r_rsp_rdata   <= o_csr_rdata;
            r_rsp_illegal <= o_csr_illegal;
            r_rsp_timeout <= 1'b0;
        end else if (w_expire) begin
            r_rsp_rdata   <= '0;
            r_rsp_illegal <= 1'b1;
            r_rsp_timeout <= 1'b1;
        end
    end

    assign req_rdy         = (r_state == ST_IDLE);
    assign rsp_vld         = (r_state == ST_RESP);
    assign rsp_rdata       = r_rsp_rdata;
    assign rsp_illegal     = r_rsp_illegal;
    assign rsp_timeout     = r_rsp_timeout;
    assign csr_addr        = r_csr_addr;
    assign csr_rd          = r_csr_rd;
    assign intp_file_sel   = r_sel;
    assign priv_is_illegal = r_priv_ill;
    assign i_csr_v         = r_v;
    assign i_csr_wdata_vld = r_wdata_vld;
    assign i_csr_wdata     = r_wdata;
    assign i_csr_wdata_op  = r_op;

endmodule
`default_nettype wire

// File: tb/tb_imsic_csr_req.sv
`default_nettype none
// ============================================================================
// Module   : tb_imsic_csr_req
// Purpose  : Directed self-checking bench for imsic_csr_req.
// Revision : 1.0 - initial release
// ============================================================================
module tb_imsic_csr_req;

    localparam int c_timeout = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_vld;
    logic        req_rdy;
    logic [11:0] req_iselect;
    logic [1:0]  req_priv;
    logic        req_v;
    logic [5:0]  req_vgein;
    logic        req_wen;
    logic [1:0]  req_op;
    logic [63:0] req_wdata;
    logic        rsp_vld;
    logic        rsp_rdy;
    logic [63:0] rsp_rdata;
    logic        rsp_illegal;
    logic        rsp_timeout;
    logic [11:0] csr_addr;
    logic        csr_rd;
    logic [2:0]  intp_file_sel;
    logic        priv_is_illegal;
    logic        i_csr_v;
    logic        i_csr_wdata_vld;
    logic [63:0] i_csr_wdata;
    logic [1:0]  i_csr_wdata_op;
    logic        o_csr_rdata_vld;
    logic [63:0] o_csr_rdata;
    logic        o_csr_illegal;

    int checks = 0;
    int errors = 0;

    imsic_csr_req #(
        .NR_INTP_FILES   (7),
        .XLEN            (64),
        .INTP_FILE_WIDTH (3),
        .TIMEOUT_CYC     (c_timeout)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .req_vld         (req_vld),
        .req_rdy         (req_rdy),
        .req_iselect     (req_iselect),
        .req_priv        (req_priv),
        .req_v           (req_v),
        .req_vgein       (req_vgein),
        .req_wen         (req_wen),
        .req_op          (req_op),
        .req_wdata       (req_wdata),
        .rsp_vld         (rsp_vld),
        .rsp_rdy         (rsp_rdy),
        .rsp_rdata       (rsp_rdata),
        .rsp_illegal     (rsp_illegal),
        .rsp_timeout     (rsp_timeout),
        .csr_addr        (csr_addr),
        .csr_rd          (csr_rd),
        .intp_file_sel   (intp_file_sel),
        .priv_is_illegal (priv_is_illegal),
        .i_csr_v         (i_csr_v),
        .i_csr_wdata_vld (i_csr_wdata_vld),
        .i_csr_wdata     (i_csr_wdata),
        .i_csr_wdata_op  (i_csr_wdata_op),
        .o_csr_rdata_vld (o_csr_rdata_vld),
        .o_csr_rdata     (o_csr_rdata),
        .o_csr_illegal   (o_csr_illegal)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_vals(input string name);
        check({name, ":req_rdy"},   req_rdy, 1);
        check({name, ":rsp_vld"},   rsp_vld, 0);
        check({name, ":rsp_rdata"}, rsp_rdata, 0);
        check({name, ":rsp_ill"},   rsp_illegal, 0);
        check({name, ":rsp_to"},    rsp_timeout, 0);
        check({name, ":addr"},      csr_addr, 0);
        check({name, ":csr_rd"},    csr_rd, 0);
        check({name, ":sel"},       intp_file_sel, 0);
        check({name, ":pill"},      priv_is_illegal, 0);
        check({name, ":v"},         i_csr_v, 0);
        check({name, ":wvld"},      i_csr_wdata_vld, 0);
        check({name, ":wdata"},     i_csr_wdata, 0);
        check({name, ":op"},        i_csr_wdata_op, 0);
    endtask

    // d: WAIT cycle index carrying the IMSIC strobe (negative = never).
    task automatic do_access(input string name, input logic [1:0] priv, input logic v,
                             input logic [5:0] vgein, input logic [11:0] isel,
                             input logic wen, input logic [1:0] op, input logic [63:0] wdata,
                             input int d, input logic [63:0] rdata, input logic ill,
                             input logic [2:0] exp_sel, input logic exp_pill, input int hold);
        logic [63:0] exp_rdata;
        logic        exp_ill;
        logic        exp_to;
        int          rsp_at;
        exp_rdata = (d >= 0) ? rdata : 64'd0;
        exp_ill   = (d >= 0) ? ill : 1'b1;
        exp_to    = (d >= 0) ? 1'b0 : 1'b1;
        rsp_at    = (d >= 0) ? d + 1 : c_timeout;

        check({name, ":idle_rdy"}, req_rdy, 1);
        req_priv    = priv;
        req_v       = v;
        req_vgein   = vgein;
        req_iselect = isel;
        req_wen     = wen;
        req_op      = op;
        req_wdata   = wdata;
        req_vld     = 1'b1;
        tick();
        req_vld     = 1'b0;
        // T+1: ISSUE
        check({name, ":csr_rd"}, csr_rd, 1);
        check({name, ":addr"},   csr_addr, isel);
        check({name, ":sel"},    intp_file_sel, exp_sel);
        check({name, ":pill"},   priv_is_illegal, exp_pill);
        check({name, ":v"},      i_csr_v, v);
        check({name, ":wvld"},   i_csr_wdata_vld, wen);
        check({name, ":wdata"},  i_csr_wdata, wdata);
        check({name, ":op"},     i_csr_wdata_op, op);
        check({name, ":busy"},   req_rdy, 0);
        tick();
        // T+2: WAIT
        check({name, ":csr_rd_off"}, csr_rd, 0);
        check({name, ":wvld_off"},   i_csr_wdata_vld, 0);
        for (int k = 0; k < rsp_at; k++) begin
            o_csr_rdata_vld = (k == d);
            o_csr_rdata     = (k == d) ? rdata : 64'hDEAD_0000_DEAD_0000;
            o_csr_illegal   = (k == d) ? ill : 1'b0;
            check({name, ":wait_vld"}, rsp_vld, 0);
            tick();
        end
        o_csr_rdata_vld = 1'b0;
        o_csr_rdata     = 64'd0;
        o_csr_illegal   = 1'b0;
        for (int h = 0; h <= hold; h++) begin
            check({name, ":rsp_vld"},   rsp_vld, 1);
            check({name, ":rsp_rdata"}, rsp_rdata, exp_rdata);
            check({name, ":rsp_ill"},   rsp_illegal, exp_ill);
            check({name, ":rsp_to"},    rsp_timeout, exp_to);
            check({name, ":rsp_busy"},  req_rdy, 0);
            if (h < hold) begin
                // Stray strobes during RESP must not disturb the response.
                o_csr_rdata_vld = 1'b1;
                o_csr_rdata     = 64'hBAD0_BAD0_BAD0_BAD0;
                o_csr_illegal   = ~exp_ill;
                tick();
                o_csr_rdata_vld = 1'b0;
                o_csr_rdata     = 64'd0;
                o_csr_illegal   = 1'b0;
            end
        end
        rsp_rdy = 1'b1;
        tick();
        rsp_rdy = 1'b0;
        check({name, ":done_vld"}, rsp_vld, 0);
        check({name, ":done_rdy"}, req_rdy, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst             = 1'b1;
        req_vld         = 1'b0;
        req_iselect     = '0;
        req_priv        = '0;
        req_v           = 1'b0;
        req_vgein       = '0;
        req_wen         = 1'b0;
        req_op          = '0;
        req_wdata       = '0;
        rsp_rdy         = 1'b0;
        o_csr_rdata_vld = 1'b0;
        o_csr_rdata     = '0;
        o_csr_illegal   = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        check_reset_vals("reset");

        do_access("mrd",   2'd3, 1'b0, 6'd0, 12'h070, 1'b0, 2'b01, 64'd0,
                  0, 64'd1, 1'b0, 3'd0, 1'b0, 0);
        do_access("vsw",   2'd1, 1'b1, 6'd2, 12'h0C0, 1'b1, 2'b10, 64'hF0,
                  0, 64'h1234_5678_9ABC_DEF0, 1'b0, 3'd3, 1'b0, 5);
        do_access("vg0",   2'd1, 1'b1, 6'd0, 12'h070, 1'b0, 2'b01, 64'd0,
                  2, 64'd0, 1'b1, 3'd0, 1'b1, 0);
        do_access("vg6",   2'd1, 1'b1, 6'd6, 12'h072, 1'b1, 2'b01, 64'h3,
                  1, 64'd0, 1'b1, 3'd0, 1'b1, 0);
        do_access("vg5",   2'd1, 1'b1, 6'd5, 12'h080, 1'b0, 2'b01, 64'd0,
                  3, 64'hAB, 1'b0, 3'd6, 1'b0, 0);
        do_access("priv2", 2'd2, 1'b0, 6'd0, 12'h070, 1'b0, 2'b01, 64'd0,
                  0, 64'd0, 1'b1, 3'd0, 1'b1, 0);
        do_access("srd",   2'd1, 1'b0, 6'd0, 12'h0FF, 1'b0, 2'b11, 64'h55,
                  0, 64'h8000_0000_0000_0001, 1'b0, 3'd1, 1'b0, 1);
        do_access("tmo",   2'd3, 1'b0, 6'd0, 12'h070, 1'b1, 2'b01, 64'h9,
                  -1, 64'd0, 1'b0, 3'd0, 1'b0, 0);
        do_access("term",  2'd3, 1'b0, 6'd0, 12'h071, 1'b0, 2'b01, 64'd0,
                  c_timeout - 1, 64'h77, 1'b0, 3'd0, 1'b0, 0);

        // Reset while waiting abandons the access; a late strobe is ignored.
        req_priv    = 2'd1;
        req_v       = 1'b1;
        req_vgein   = 6'd3;
        req_iselect = 12'h0C1;
        req_wen     = 1'b1;
        req_op      = 2'b11;
        req_wdata   = 64'hCAFE;
        req_vld     = 1'b1;
        tick();
        req_vld = 1'b0;
        check("rstw:sel_pre", intp_file_sel, 3'd4);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_reset_vals("rstw");
        o_csr_rdata_vld = 1'b1;
        o_csr_rdata     = 64'h1111;
        o_csr_illegal   = 1'b1;
        tick();
        o_csr_rdata_vld = 1'b0;
        o_csr_rdata     = 64'd0;
        o_csr_illegal   = 1'b0;
        check("late:rsp_vld",   rsp_vld, 0);
        check("late:req_rdy",   req_rdy, 1);
        check("late:rsp_rdata", rsp_rdata, 0);
        tick();
        check("late2:rsp_vld",  rsp_vld, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
